npu_inst_loader: RTL and testbench
==================================

# npu_inst_loader

Fills the NPU instruction RAM from DDR before a program runs. On command it reads N 128-bit instructions from a DDR base address as 32-bit words and packs every four words into one instruction. It writes each instruction to the instruction RAM read by the instruction-sequencing FSM, then appends a 128'd0 NOP terminator. With the autostart option compiled in, it also launches the NPU and waits for it to finish.

## Interface
- DATA_WIDTH, 32, DDR word width
- INST_WIDTH, 128, instruction width; must equal 4*DATA_WIDTH
- INST_ADDR_WIDTH, 10, instruction RAM address width
- MAX_OUTSTANDING, 8, maximum DDR reads accepted but not yet returned
---
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request; sampled only in IDLE
- load_base_addr  in  DATA_WIDTH  DDR word address of word 0; captured with load_start
- load_inst_num  in  16  number of instructions N; captured with load_start
- load_ready  out  1  high when idle; reset value 1
- load_done  out  1  one-cycle pulse when the load completes; reset value 0
- inst_ram_wr_en  out  1  instruction RAM write strobe; reset value 0
- inst_ram_wr_addr  out  INST_ADDR_WIDTH  instruction RAM write index; reset value 0
- inst_ram_wr_data  out  INST_WIDTH  instruction RAM write data; reset value 0
- DDR_READ_CLK  out  1  equals clk
- DDR_READ_ADDR  out  DATA_WIDTH  read word address; reset value 0
- DDR_READ_REQ  out  1  read request; reset value 0
- DDR_READ_READY  in  1  request accepted in any cycle where REQ and READY are both high
- DDR_READ_DATA  in  DATA_WIDTH  returned read data, in request order
- DDR_READ_DATA_VALID  in  1  qualifies DDR_READ_DATA
- npu_inst_start  out  1  one-cycle NPU launch pulse; reset value 0
- npu_inst_ready  in  1  NPU idle flag

## Operation
- States are IDLE, REQ, DRAIN, TERM, LAUNCH and WAIT_NPU.
- **IDLE**: load_start captures base and N, clamped to 2^INST_ADDR_WIDTH-1. Clears counters. Next state is REQ, or TERM if N=0. load_start outside IDLE is ignored.
- **REQ**: holds DDR_READ_REQ high with the current address. On each accept, address and issued count increment by 1.
  - REQ deasserts combinationally while outstanding = MAX_OUTSTANDING; outstanding = issued - received.
  - After 4N accepts, go to DRAIN.
- **Packing** (all states): each DATA_VALID shifts its word in. Word k (0..3) of an instruction lands at bits [32k+31:32k].
  - The 4th word fires a RAM write at index i, after which i increments.
  - A DATA_VALID in IDLE is dropped.
- **DRAIN**: waits until received = 4N, then goes to TERM.
- **TERM**: writes 128'd0 at index N (for N=0, index 0). Then pulses load_done and goes to LAUNCH if autostart is enabled, else IDLE.
- **LAUNCH**: pulses npu_inst_start for one cycle, then goes to WAIT_NPU.
- **WAIT_NPU**: waits for npu_inst_ready to go low, then high, then goes to IDLE.
- Width rules: issued and received counters are INST_ADDR_WIDTH+2 bits; the DDR address wraps modulo 2^DATA_WIDTH.
- A DATA_VALID and an accept in the same cycle update both counters, with outstanding unchanged.
- rst mid-operation forces IDLE and clears all outputs to their reset values. Data returning after reset is dropped.

## Timing
- load_start in cycle t gives DDR_READ_REQ high with ADDR = base in cycle t+1.
- With READY held high, consecutive accepts advance the address each cycle.
- RAM write is registered: wr_en is high in the cycle after the 4th DATA_VALID of an instruction.
- The NOP write occurs at least 1 cycle after the last instruction write.
- load_done is high in the cycle after the NOP write.
- load_ready = (state==IDLE), registered: low from t+1 until one cycle after the return to IDLE.
- npu_inst_start is high in the cycle after load_done.

## Configuration
- NPU_INST_LOADER_AUTOSTART_EN
  - Defined: LAUNCH and WAIT_NPU are present.
  - Undefined: those states are absent, npu_inst_start is tied 0, npu_inst_ready is unused, and TERM returns directly to IDLE.

## Structure
- Shared package npu_pkg holds:
  - the state encoding for this block;
  - the NOP constant 128'd0;
  - the WORDS_PER_INST = INST_WIDTH/DATA_WIDTH constant.
- Sub-module npu_inst_packer: 2-bit word counter plus a 128-bit shift register. It takes data_valid/data and emits inst_valid/inst; cleared by rst.

## Test plan
- N=2, base=0x100, READY always high, 1-cycle read latency:
  - addresses 0x100..0x107 are issued;
  - RAM[0] = {w3,w2,w1,w0} and RAM[1] = {w7..w4};
  - RAM[2] = 0;
  - exactly one load_done.
- N=0: no DDR requests; single write of 0 at index 0; load_done.
- MAX_OUTSTANDING=8, N=4, reads returned only after 20 cycles: REQ drops after 8 accepts and resumes as data returns; all 16 words are packed correctly.
- Random READY and DATA_VALID gaps, N=5: RAM contents match the DDR model and the NOP lands at index 5.
- rst asserted in the cycle after the 6th accept:
  - REQ=0, load_ready=1, no further RAM writes;
  - a new load with N=1 completes correctly.
- AUTOSTART_EN, N=1: npu_inst_start pulses once after load_done. load_ready stays low until the NPU model drops npu_inst_ready and raises it 50 cycles later.

Source files
------------

// File: rtl/npu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared definitions for the NPU instruction-loader slice:
//                loader state encoding, the NOP terminator value and the
//                number of DDR words packed into one instruction.
//  Revision    : 1.0  initial release
// ============================================================================
package npu_pkg;

    // Reference widths used to derive the packing ratio.
    localparam int c_PKG_DATA_WIDTH = 32;
    localparam int c_PKG_INST_WIDTH = 128;

    // DDR words per instruction word.
    localparam int WORDS_PER_INST = c_PKG_INST_WIDTH / c_PKG_DATA_WIDTH;

    // Terminator written after the last loaded instruction.
    localparam logic [127:0] c_NOP_INST = 128'd0;

    // Loader state encoding (kept as plain constants for legacy tooling).
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_REQ      = 3'd1;
    localparam logic [2:0] c_ST_DRAIN    = 3'd2;
    localparam logic [2:0] c_ST_TERM     = 3'd3;
    localparam logic [2:0] c_ST_LAUNCH   = 3'd4;
    localparam logic [2:0] c_ST_WAIT_NPU = 3'd5;

endpackage
`default_nettype wire

// File: rtl/npu_inst_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : npu_inst_packer
//  Description : Packs consecutive DDR words into instruction words. Word k of
//                an instruction lands at bits [DATA_WIDTH*k +: DATA_WIDTH].
//                inst_valid/inst are combinational and flag the cycle in which
//                the final word of an instruction arrives.
//  Ports       : clk, rst (sync, active high)
//                data_valid, data   - incoming DDR word
//                inst_valid, inst   - completed instruction
//  Revision    : 1.0  initial release
// ============================================================================
module npu_inst_packer
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst
);

    localparam int c_HOLD_W = INST_WIDTH - DATA_WIDTH;

    logic [1:0]            r_word_cnt;
    // Holds the words received so far, oldest word at the bottom.
    logic [c_HOLD_W-1:0]   r_hold;
    logic [INST_WIDTH-1:0] w_full;

    // New word enters at the top; after the last word the oldest sits at bit 0.
    assign w_full     = {data, r_hold};
    assign inst       = w_full;
    assign inst_valid = data_valid && (r_word_cnt == 2'(WORDS_PER_INST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= 2'd0;
            r_hold     <= '0;
        end else if (data_valid) begin
            r_word_cnt <= r_word_cnt + 2'd1;
            r_hold     <= w_full[INST_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/npu_inst_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : npu_inst_loader
//  Description : Loads N 128-bit instructions from DDR (as 32-bit words) into
//                the NPU instruction RAM, then writes a NOP terminator at
//                index N. Optionally launches the NPU and waits for it.
//  Config      : NPU_INST_LOADER_AUTOSTART_EN - adds LAUNCH/WAIT_NPU states.
//  Ports       : clk, rst                         clock, sync active-high reset
//                load_start/base_addr/inst_num    load command (IDLE only)
//                load_ready, load_done            status
//                inst_ram_wr_en/addr/data         instruction RAM write port
//                DDR_READ_*                       DDR read channel
//                npu_inst_start, npu_inst_ready   NPU launch handshake
//  Revision    : 1.0  initial release
// ============================================================================
module npu_inst_loader
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int INST_WIDTH      = 128,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [DATA_WIDTH-1:0]      load_base_addr,
    input  logic [15:0]                load_inst_num,
    output logic                       load_ready,
    output logic                       load_done,
    output logic                       inst_ram_wr_en,
    output logic [INST_ADDR_WIDTH-1:0] inst_ram_wr_addr,
    output logic [INST_WIDTH-1:0]      inst_ram_wr_data,
    output logic                       DDR_READ_CLK,
    output logic [DATA_WIDTH-1:0]      DDR_READ_ADDR,
    output logic                       DDR_READ_REQ,
    input  logic                       DDR_READ_READY,
    input  logic [DATA_WIDTH-1:0]      DDR_READ_DATA,
    input  logic                       DDR_READ_DATA_VALID,
    output logic                       npu_inst_start,
    input  logic                       npu_inst_ready
);

    localparam int c_CNT_W = INST_ADDR_WIDTH + 2;
    localparam int c_MAX_N = (1 << INST_ADDR_WIDTH) - 1;

    logic [2:0]                 r_state;
    logic [DATA_WIDTH-1:0]      r_addr;
    logic [INST_ADDR_WIDTH-1:0] r_num;
    logic [INST_ADDR_WIDTH-1:0] r_inst_idx;
    logic [c_CNT_W-1:0]         r_issued;
    logic [c_CNT_W-1:0]         r_received;
    logic                       r_ready;
    logic                       r_done;
    logic                       r_wr_en;
    logic [INST_ADDR_WIDTH-1:0] r_wr_addr;
    logic [INST_WIDTH-1:0]      r_wr_data;

    logic [INST_ADDR_WIDTH-1:0] w_clamped_num;
    logic [c_CNT_W-1:0]         w_total_words;
    logic [c_CNT_W-1:0]         w_outstanding;
    logic                       w_req;
    logic                       w_accept;
    logic                       w_word_valid;
    logic                       w_inst_valid;
    logic [INST_WIDTH-1:0]      w_inst;

    // Largest program that still leaves room for the terminator.
    assign w_clamped_num = (load_inst_num > 16'(c_MAX_N)) ? INST_ADDR_WIDTH'(c_MAX_N)
                                                          : load_inst_num[INST_ADDR_WIDTH-1:0];
    // Four DDR words per instruction.
    assign w_total_words = {r_num, 2'b00};
    assign w_outstanding = r_issued - r_received;

    // Throttle combinationally so the read window never exceeds its limit.
    assign w_req        = (r_state == c_ST_REQ) && (w_outstanding != c_CNT_W'(MAX_OUTSTANDING));
    assign w_accept     = w_req && DDR_READ_READY;
    // Returns that arrive while idle (e.g. after a reset) are discarded.
    assign w_word_valid = DDR_READ_DATA_VALID && (r_state != c_ST_IDLE);

    assign DDR_READ_CLK     = clk;
    assign DDR_READ_REQ     = w_req;
    assign DDR_READ_ADDR    = r_addr;
    assign load_ready       = r_ready;
    assign load_done        = r_done;
    assign inst_ram_wr_en   = r_wr_en;
    assign inst_ram_wr_addr = r_wr_addr;
    assign inst_ram_wr_data = r_wr_data;

`ifdef NPU_INST_LOADER_AUTOSTART_EN
    logic r_npu_start;
    logic r_npu_seen_low;
    assign npu_inst_start = r_npu_start;
`else
    logic w_unused_npu_ready;
    assign w_unused_npu_ready = npu_inst_ready;
    assign npu_inst_start     = 1'b0;
`endif

    npu_inst_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .data_valid (w_word_valid),
        .data       (DDR_READ_DATA),
        .inst_valid (w_inst_valid),
        .inst       (w_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_num      <= '0;
            r_inst_idx <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef NPU_INST_LOADER_AUTOSTART_EN
            r_npu_start    <= 1'b0;
            r_npu_seen_low <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
`ifdef NPU_INST_LOADER_AUTOSTART_EN
            r_npu_start <= 1'b0;
`endif
            if (w_accept) begin
                r_addr   <= r_addr + DATA_WIDTH'(1);
                r_issued <= r_issued + c_CNT_W'(1);
            end
            if (w_word_valid) begin
                r_received <= r_received + c_CNT_W'(1);
            end
            if (w_inst_valid) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_inst_idx;
                r_wr_data  <= w_inst;
                r_inst_idx <= r_inst_idx + INST_ADDR_WIDTH'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (load_start) begin
                        r_addr     <= load_base_addr;
                        r_num      <= w_clamped_num;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_inst_idx <= '0;
                        r_ready    <= 1'b0;
                        if (w_clamped_num == '0) begin
                            // Empty program: the terminator is the only write.
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= '0;
                            r_wr_data <= INST_WIDTH'(c_NOP_INST);
                            r_state   <= c_ST_TERM;
                        end else begin
                            r_state <= c_ST_REQ;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (w_accept && ((r_issued + c_CNT_W'(1)) == w_total_words)) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    // The NOP write is registered here so it is on the RAM
                    // port during TERM; load_done follows one cycle later.
                    if (r_received == w_total_words) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_num;
                        r_wr_data <= INST_WIDTH'(c_NOP_INST);
                        r_state   <= c_ST_TERM;
                    end
                end
                c_ST_TERM: begin
                    r_done <= 1'b1;
`ifdef NPU_INST_LOADER_AUTOSTART_EN
                    r_state <= c_ST_LAUNCH;
`else
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
`endif
                end
`ifdef NPU_INST_LOADER_AUTOSTART_EN
                c_ST_LAUNCH: begin
                    r_npu_start    <= 1'b1;
                    r_npu_seen_low <= 1'b0;
                    r_state        <= c_ST_WAIT_NPU;
                end
                c_ST_WAIT_NPU: begin
                    // Require a full busy period (low then high) before idling.
                    if (!npu_inst_ready) begin
                        r_npu_seen_low <= 1'b1;
                    end else if (r_npu_seen_low) begin
                        r_state <= c_ST_IDLE;
                        r_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npu_inst_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_npu_inst_loader
//  Description : Self-checking bench for npu_inst_loader. A DDR responder with
//                randomized READY/VALID gaps and latency serves a hashed
//                memory image; expected RAM contents are rebuilt from that
//                image. Set NPU_INST_LOADER_AUTOSTART_EN to cover launch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_npu_inst_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic [31:0]  load_base_addr;
    logic [15:0]  load_inst_num;
    logic         load_ready;
    logic         load_done;
    logic         inst_ram_wr_en;
    logic [9:0]   inst_ram_wr_addr;
    logic [127:0] inst_ram_wr_data;
    logic         DDR_READ_CLK;
    logic [31:0]  DDR_READ_ADDR;
    logic         DDR_READ_REQ;
    logic         DDR_READ_READY;
    logic [31:0]  DDR_READ_DATA;
    logic         DDR_READ_DATA_VALID;
    logic         npu_inst_start;
    logic         npu_inst_ready;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // DDR responder configuration and bookkeeping
    int           ready_pct = 100;
    int           valid_pct = 100;
    int           lat_min   = 1;
    int           lat_max   = 1;
    logic [31:0]  salt      = 32'h5A5A_1234;
    logic [31:0]  rq_addr[$];
    longint       rq_due[$];
    logic [31:0]  acc_addr[$];
    int           acc_cnt, ret_cnt, max_out, req_at_max;

    // Write / pulse monitor
    logic [9:0]   wr_idx[$];
    logic [127:0] wr_dat[$];
    longint       wr_cyc[$];
    int           done_cnt, start_cnt;
    longint       done_cyc, start_cyc, npu_rise_cyc;

    npu_inst_loader u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_start          (load_start),
        .load_base_addr      (load_base_addr),
        .load_inst_num       (load_inst_num),
        .load_ready          (load_ready),
        .load_done           (load_done),
        .inst_ram_wr_en      (inst_ram_wr_en),
        .inst_ram_wr_addr    (inst_ram_wr_addr),
        .inst_ram_wr_data    (inst_ram_wr_data),
        .DDR_READ_CLK        (DDR_READ_CLK),
        .DDR_READ_ADDR       (DDR_READ_ADDR),
        .DDR_READ_REQ        (DDR_READ_REQ),
        .DDR_READ_READY      (DDR_READ_READY),
        .DDR_READ_DATA       (DDR_READ_DATA),
        .DDR_READ_DATA_VALID (DDR_READ_DATA_VALID),
        .npu_inst_start      (npu_inst_start),
        .npu_inst_ready      (npu_inst_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DDR memory image
    function automatic logic [31:0] ddr_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // DDR responder: in-order returns after a random latency, random gaps.
    initial begin
        DDR_READ_READY      = 1'b0;
        DDR_READ_DATA_VALID = 1'b0;
        DDR_READ_DATA       = '0;
        forever begin
            @(negedge clk);
            if ((acc_cnt - ret_cnt) > max_out) max_out = acc_cnt - ret_cnt;
            if (DDR_READ_REQ && (acc_cnt - ret_cnt) >= 8) req_at_max++;
            if (rq_addr.size() > 0 && rq_due[0] <= cyc && $urandom_range(99) < valid_pct) begin
                DDR_READ_DATA_VALID = 1'b1;
                DDR_READ_DATA       = ddr_word(rq_addr[0]);
                void'(rq_addr.pop_front());
                void'(rq_due.pop_front());
                ret_cnt++;
            end else begin
                DDR_READ_DATA_VALID = 1'b0;
                DDR_READ_DATA       = $urandom;
            end
            DDR_READ_READY = ($urandom_range(99) < ready_pct);
            if (DDR_READ_REQ && DDR_READ_READY) begin
                acc_addr.push_back(DDR_READ_ADDR);
                rq_addr.push_back(DDR_READ_ADDR);
                rq_due.push_back(cyc + longint'($urandom_range(lat_max, lat_min)));
                acc_cnt++;
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (inst_ram_wr_en) begin
                wr_idx.push_back(inst_ram_wr_addr);
                wr_dat.push_back(inst_ram_wr_data);
                wr_cyc.push_back(cyc);
            end
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (npu_inst_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
        end
    end

    // NPU model: goes busy a few cycles after launch, idle 50 cycles later.
    initial begin
        npu_inst_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (npu_inst_start) begin
                repeat (3) @(negedge clk);
                npu_inst_ready = 1'b0;
                repeat (50) @(negedge clk);
                npu_inst_ready = 1'b1;
                npu_rise_cyc   = cyc;
            end
        end
    end

    task automatic clear_logs();
        acc_addr.delete();
        wr_idx.delete();
        wr_dat.delete();
        wr_cyc.delete();
        acc_cnt    = 0;
        ret_cnt    = 0;
        max_out    = 0;
        req_at_max = 0;
        done_cnt   = 0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        load_start     = 1'b0;
        load_base_addr = '0;
        load_inst_num  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Issue one load command and wait (bounded) for load_done.
    task automatic run_load(input logic [31:0] base, input int n, input string tag);
        int guard;
        clear_logs();
        @(negedge clk);
        load_base_addr = base;
        load_inst_num  = 16'(n);
        load_start     = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_low_after_start: got %b want 0", tag, load_ready);
        end
        total++;
        if (DDR_READ_REQ !== (n > 0) || (n > 0 && DDR_READ_ADDR !== base)) begin
            bad++;
            $display("FAIL %s first_req: got req=%b addr=%h want req=%b addr=%h",
                     tag, DDR_READ_REQ, DDR_READ_ADDR, (n > 0), base);
        end
        guard = 0;
        while (done_cnt == 0 && guard < 20000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s load_timeout: got no load_done want one within %0d cycles", tag, guard);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Compare everything observed for a load against the memory image.
    task automatic check_load(input logic [31:0] base, input int n, input string tag);
        int           ne;
        bit           addr_ok;
        logic [127:0] exp;
        ne = (n > 1023) ? 1023 : n;
        total++;
        if (acc_addr.size() != 4 * ne) begin
            bad++;
            $display("FAIL %s accept_count: got %0d want %0d", tag, acc_addr.size(), 4 * ne);
        end
        addr_ok = 1'b1;
        for (int k = 0; k < acc_addr.size() && k < 4 * ne; k++)
            if (acc_addr[k] !== base + 32'(k)) addr_ok = 1'b0;
        total++;
        if (!addr_ok) begin
            bad++;
            $display("FAIL %s addr_sequence: got first=%h want consecutive from %h", tag,
                     (acc_addr.size() > 0) ? acc_addr[0] : 32'h0, base);
        end
        total++;
        if (wr_idx.size() != ne + 1) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wr_idx.size(), ne + 1);
        end
        for (int i = 0; i <= ne && i < wr_idx.size(); i++) begin
            exp = '0;
            if (i < ne)
                for (int j = 0; j < 4; j++) exp[32*j +: 32] = ddr_word(base + 32'(4 * i + j));
            total++;
            if (wr_idx[i] !== 10'(i) || wr_dat[i] !== exp) begin
                bad++;
                $display("FAIL %s ram_write[%0d]: got idx=%0d data=%h want idx=%0d data=%h",
                         tag, i, wr_idx[i], wr_dat[i], i, exp);
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", tag, done_cnt);
        end
        if (wr_cyc.size() == ne + 1) begin
            total++;
            if (done_cyc != wr_cyc[ne] + 1) begin
                bad++;
                $display("FAIL %s done_timing: got cycle %0d want %0d", tag, done_cyc, wr_cyc[ne] + 1);
            end
            if (ne > 0) begin
                total++;
                if (wr_cyc[ne] <= wr_cyc[ne-1]) begin
                    bad++;
                    $display("FAIL %s nop_after_last: got nop cycle %0d want > %0d",
                             tag, wr_cyc[ne], wr_cyc[ne-1]);
                end
            end
        end
`ifndef NPU_INST_LOADER_AUTOSTART_EN
        total++;
        if (load_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_after_done: got %b want 1", tag, load_ready);
        end
`endif
    endtask

    task automatic test_reset();
        total++;
        if (load_ready !== 1'b1 || load_done !== 1'b0 || DDR_READ_REQ !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: got ready=%b done=%b req=%b want 1 0 0",
                     load_ready, load_done, DDR_READ_REQ);
        end
        total++;
        if (inst_ram_wr_en !== 1'b0 || inst_ram_wr_addr !== 10'd0 || inst_ram_wr_data !== 128'd0) begin
            bad++;
            $display("FAIL reset_ram_port: got en=%b addr=%h data=%h want zeros",
                     inst_ram_wr_en, inst_ram_wr_addr, inst_ram_wr_data);
        end
        total++;
        if (DDR_READ_ADDR !== 32'd0 || npu_inst_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_ddr_npu: got addr=%h start=%b want 0 0", DDR_READ_ADDR, npu_inst_start);
        end
    endtask

    task automatic test_basic();
        ready_pct = 100; valid_pct = 100; lat_min = 1; lat_max = 1;
        run_load(32'h0000_0100, 2, "basic");
        check_load(32'h0000_0100, 2, "basic");
    endtask

    task automatic test_zero();
        logic [31:0] base;
        base = $urandom;
        run_load(base, 0, "zero");
        check_load(base, 0, "zero");
    endtask

    task automatic test_outstanding();
        ready_pct = 100; valid_pct = 100; lat_min = 20; lat_max = 20;
        salt = $urandom;
        run_load(32'h0000_2000, 4, "outst");
        total++;
        if (max_out != 8 || req_at_max != 0) begin
            bad++;
            $display("FAIL outst_window: got max=%0d req_at_limit=%0d want 8 0", max_out, req_at_max);
        end
        check_load(32'h0000_2000, 4, "outst");
    endtask

    task automatic test_random();
        ready_pct = 60; valid_pct = 70; lat_min = 1; lat_max = 4;
        salt = $urandom;
        // Base chosen so the word addresses wrap past 2^32.
        run_load(32'hFFFF_FFFA, 5, "random");
        check_load(32'hFFFF_FFFA, 5, "random");
        total++;
        if (req_at_max != 0) begin
            bad++;
            $display("FAIL random_window: got req_at_limit=%0d want 0", req_at_max);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] base;
        ready_pct = 100; valid_pct = 100; lat_min = 1; lat_max = 2;
        base = $urandom;
        run_load(base, 16'hFFFF, "clamp");
        check_load(base, 16'hFFFF, "clamp");
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [31:0] base;
        ready_pct = 100; valid_pct = 100; lat_min = 5; lat_max = 5;
        base = $urandom;
        clear_logs();
        @(negedge clk);
        load_base_addr = base;
        load_inst_num  = 16'd3;
        load_start     = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        #1;
        guard = 0;
        while (acc_cnt < 6 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        total++;
        if (acc_cnt < 6) begin
            bad++;
            $display("FAIL rstmid_accepts: got %0d want 6 before timeout", acc_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (DDR_READ_REQ !== 1'b0 || load_ready !== 1'b1 || inst_ram_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state: got req=%b ready=%b wr=%b want 0 1 0",
                     DDR_READ_REQ, load_ready, inst_ram_wr_en);
        end
        rst = 1'b0;
        wr_idx.delete();
        wr_dat.delete();
        wr_cyc.delete();
        done_cnt = 0;
        repeat (40) @(negedge clk);
        #1;
        total++;
        if (wr_idx.size() != 0 || done_cnt != 0 || DDR_READ_REQ !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet: got writes=%0d done=%0d req=%b want 0 0 0",
                     wr_idx.size(), done_cnt, DDR_READ_REQ);
        end
        base = $urandom;
        run_load(base, 1, "rstmid_reload");
        check_load(base, 1, "rstmid_reload");
    endtask

`ifdef NPU_INST_LOADER_AUTOSTART_EN
    task automatic test_autostart();
        int guard;
        longint ready_cyc;
        logic [31:0] base;
        ready_pct = 100; valid_pct = 100; lat_min = 1; lat_max = 3;
        base      = $urandom;
        start_cnt = 0;
        run_load(base, 1, "auto");
        check_load(base, 1, "auto");
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL auto_ready_busy: got %b want 0", load_ready);
        end
        guard = 0;
        while (load_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        ready_cyc = cyc;
        total++;
        if (start_cnt != 1 || start_cyc != done_cyc + 1) begin
            bad++;
            $display("FAIL auto_start_pulse: got count=%0d cycle=%0d want 1 at %0d",
                     start_cnt, start_cyc, done_cyc + 1);
        end
        total++;
        if (load_ready !== 1'b1 || ready_cyc <= npu_rise_cyc || ready_cyc > npu_rise_cyc + 3) begin
            bad++;
            $display("FAIL auto_ready_return: got ready=%b at %0d want 1 shortly after %0d",
                     load_ready, ready_cyc, npu_rise_cyc);
        end
    endtask
`else
    task automatic test_no_autostart();
        total++;
        if (start_cnt != 0 || npu_inst_start !== 1'b0) begin
            bad++;
            $display("FAIL no_autostart: got start pulses=%0d want 0", start_cnt);
        end
    endtask
`endif

    initial begin
        acc_cnt   = 0;
        ret_cnt   = 0;
        done_cnt  = 0;
        start_cnt = 0;
        do_reset();
        test_reset();
        test_basic();
        test_zero();
        test_outstanding();
        test_random();
        test_reset_mid();
        test_clamp();
`ifdef NPU_INST_LOADER_AUTOSTART_EN
        test_autostart();
`else
        test_no_autostart();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
